// File: rtl/valve_jk_driver.sv
// valve_jk_driver: debounced irrigation valve sequencer driving a JK flip-flop's J/K inputs,
// with bounded watering time, enforced off-time and stuck-latch detection via Q feedback.
module valve_jk_driver #(
    parameter int DEB_CYCLES = 4,
    parameter int MAX_ON     = 16,
    parameter int MIN_OFF    = 8,
    parameter int CNT_W      = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       DRY,
    input  logic       TANK_LOW,
    input  logic       VALVE_Q,
    output logic       J,
    output logic       K,
    output logic       ALARM,
    output logic       TANK_ALARM,
    output logic       BUSY,
    output logic [2:0] STATE
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DEB     = 3'd1,
        OPEN    = 3'd2,
        WATER   = 3'd3,
        CLOSE   = 3'd4,
        HOLDOFF = 3'd5,
        FAULT   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dry_q, tank_q;
    logic             j_q, k_q, alarm_q;
    logic             dry_s, tank_low_s, go;

    assign dry_s      = dry_q[1];
    assign tank_low_s = tank_q[1];
    assign go         = ENABLE && dry_s && !tank_low_s;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = go ? DEB : IDLE;
            DEB:     state_d = !go ? IDLE : (cnt_q == DEB_LAST) ? OPEN : DEB;
            OPEN:    state_d = WATER;
            // a valve that never latched outranks every normal exit
            WATER:   state_d = (cnt_q != '0 && !VALVE_Q) ? FAULT :
                               (!go || cnt_q == ON_LAST) ? CLOSE : WATER;
            CLOSE:   state_d = HOLDOFF;
            HOLDOFF: state_d = (cnt_q != '0 && VALVE_Q) ? FAULT :
                               (cnt_q == OFF_LAST) ? IDLE : HOLDOFF;
            FAULT:   state_d = ENABLE ? FAULT : IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q || state_q == IDLE || state_q == FAULT) ? '0 : cnt_q + CNT_W'(1);
    end

    // J/K/ALARM are registered from the next state so they line up with STATE
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dry_q   <= '0;
            tank_q  <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dry_q   <= {dry_q[0], DRY};
            tank_q  <= {tank_q[0], TANK_LOW};
            j_q     <= state_d == OPEN;
            k_q     <= state_d == CLOSE || state_d == FAULT;
            alarm_q <= state_d == FAULT;
        end
    end

    assign J          = j_q;
    assign K          = k_q;
    assign ALARM      = alarm_q;
    assign TANK_ALARM = tank_low_s;
    assign BUSY       = state_q != IDLE;
    assign STATE      = state_q;
endmodule

// File: tb/tb_valve_jk_driver.sv
// tb_valve_jk_driver: directed scenarios plus randomized stimulus, checked every cycle
// against a behavioural model of the sequencer and a model of the valve JK flip-flop.
module tb_valve_jk_driver;
    localparam int DEB = 4, MON = 16, MOFF = 8;

    logic       CLK = 1'b0, RESET = 1'b0, ENABLE = 1'b0, DRY = 1'b0, TANK_LOW = 1'b0;
    logic       J, K, ALARM, TANK_ALARM, BUSY;
    logic [2:0] STATE;
    logic       vq;
    logic       ff_q = 1'b0;
    int         mode = 0;

    int ncmp = 0, nerr = 0;
    int first_e[7];
    int jc, kc;

    logic d1 = 1'b0, ds = 1'b0, t1 = 1'b0, ts = 1'b0;
    int   ms = 0, mt = 0, nxt;

    valve_jk_driver #(.DEB_CYCLES(DEB), .MAX_ON(MON), .MIN_OFF(MOFF), .CNT_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DRY(DRY), .TANK_LOW(TANK_LOW),
        .VALVE_Q(vq), .J(J), .K(K), .ALARM(ALARM), .TANK_ALARM(TANK_ALARM),
        .BUSY(BUSY), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    // mode 1: valve stuck closed, mode 2: valve stuck open
    assign vq = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ff_q;

    function automatic int step(input int s, input int t, input bit en, input bit go, input bit q);
        case (s)
            0: return go ? 1 : 0;
            1: return !go ? 0 : (t == DEB - 1) ? 2 : 1;
            2: return 3;
            3: return (t >= 1 && !q) ? 6 : (!go || t == MON - 1) ? 4 : 3;
            4: return 5;
            5: return (t >= 1 && q) ? 6 : (t == MOFF - 1) ? 0 : 5;
            default: return en ? 6 : 0;
        endcase
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            d1 <= 0; ds <= 0; t1 <= 0; ts <= 0; ms <= 0; mt <= 0; ff_q <= 0;
        end else begin
            d1 <= DRY; ds <= d1; t1 <= TANK_LOW; ts <= t1;
            ff_q <= (J && K) ? ~ff_q : J ? 1'b1 : K ? 1'b0 : ff_q;
            nxt = step(ms, mt, ENABLE, ENABLE && ds && !ts, vq);
            mt <= (nxt == ms) ? mt + 1 : 0;
            ms <= nxt;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("state", int'(STATE), ms);
        chk("j", int'(J), int'(ms == 2));
        chk("k", int'(K), int'(ms == 4 || ms == 6));
        chk("alarm", int'(ALARM), int'(ms == 6));
        chk("busy", int'(BUSY), int'(ms != 0));
        chk("tank_alarm", int'(TANK_ALARM), int'(ts));
    end

    task automatic watch(input int n);
        for (int i = 0; i < 7; i++) first_e[i] = 0;
        jc = 0; kc = 0;
        for (int e = 1; e <= n; e++) begin
            @(posedge CLK); #1;
            if (STATE < 7 && first_e[STATE] == 0) first_e[STATE] = e;
            jc += int'(J); kc += int'(K);
        end
    endtask

    task automatic start(input int m);
        @(negedge CLK);
        RESET = 0; mode = m; ENABLE = 1; DRY = 1; TANK_LOW = 0;
        @(negedge CLK); @(negedge CLK);
        RESET = 1;
    endtask

    initial begin
        #3;
        chk("rst_j", int'(J), 0); chk("rst_k", int'(K), 0); chk("rst_alarm", int'(ALARM), 0);
        chk("rst_busy", int'(BUSY), 0); chk("rst_state", int'(STATE), 0);
        // nominal open / water / close / holdoff
        start(0);
        watch(33);
        chk("nom_deb_edge", first_e[1], 3); chk("nom_open_edge", first_e[2], 7);
        chk("nom_water_edge", first_e[3], 8); chk("nom_close_edge", first_e[4], 24);
        chk("nom_hold_edge", first_e[5], 25); chk("nom_j_cycles", jc, 1);
        chk("nom_k_cycles", kc, 1); chk("nom_idle_33", int'(STATE), 0);
        // debounce glitch
        start(0);
        watch(3);
        chk("gl_deb_edge", first_e[1], 3);
        @(negedge CLK); DRY = 0;
        watch(10);
        chk("gl_no_open", first_e[2], 0); chk("gl_j_cycles", jc, 0); chk("gl_busy", int'(BUSY), 0);
        // dry falls mid-water
        start(0);
        watch(13);
        @(negedge CLK); DRY = 0;
        watch(2);
        chk("dry_stop_water", int'(STATE), 3);
        watch(1);
        chk("dry_stop_close", int'(STATE), 4); chk("dry_stop_k", int'(K), 1);
        // tank low mid-water
        start(0);
        watch(13);
        @(negedge CLK); TANK_LOW = 1;
        watch(2);
        chk("tank_water", int'(STATE), 3); chk("tank_alarm_on", int'(TANK_ALARM), 1);
        watch(1);
        chk("tank_close", int'(STATE), 4);
        watch(20);
        chk("tank_blocks_start", int'(STATE), 0);
        // stuck closed
        start(1);
        watch(12);
        chk("sc_fault_edge", first_e[6], 10); chk("sc_alarm", int'(ALARM), 1);
        chk("sc_k_held", int'(K), 1); chk("sc_j", int'(J), 0);
        @(negedge CLK); ENABLE = 0;
        watch(1);
        chk("sc_idle", int'(STATE), 0); chk("sc_alarm_clr", int'(ALARM), 0); chk("sc_k_clr", int'(K), 0);
        // stuck open after the close pulse
        start(0);
        watch(25);
        chk("so_holdoff", int'(STATE), 5);
        @(negedge CLK); mode = 2;
        watch(2);
        chk("so_fault_edge", first_e[6], 2); chk("so_alarm", int'(ALARM), 1);
        @(negedge CLK); ENABLE = 0; mode = 0;
        watch(1);
        chk("so_idle", int'(STATE), 0);
        // async reset during water
        start(0);
        watch(12);
        @(posedge CLK); #2 RESET = 0;
        #1;
        chk("ar_j", int'(J), 0); chk("ar_k", int'(K), 0);
        chk("ar_busy", int'(BUSY), 0); chk("ar_state", int'(STATE), 0);
        @(negedge CLK); RESET = 1;
        watch(7);
        chk("ar_restart_open", first_e[2], 7);
        // randomized
        @(negedge CLK); ENABLE = 1; DRY = 0; TANK_LOW = 0; mode = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK);
            if ($urandom_range(39) == 0) ENABLE = ~ENABLE;
            if ($urandom_range(14) == 0) DRY = ~DRY;
            if ($urandom_range(59) == 0) TANK_LOW = ~TANK_LOW;
            if ($urandom_range(199) == 0) mode = ($urandom_range(3) == 0) ? int'($urandom_range(2)) : 0;
            RESET = ($urandom_range(499) != 0);
        end
        @(negedge CLK); RESET = 1;
        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
